// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, flush, optional skid entry
// and a saturating stall counter.
module pipe_stage #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 10,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } state_t;

  state_t            state_p0, state_nxt;
  logic [DATA_W-1:0] main_data_p0, skid_data_p0;
  logic [CTRL_W-1:0] main_ctrl_p0, skid_ctrl_p0;
  logic [CNT_W-1:0]  stall_cnt_p0;
  logic              vld_p0;
  logic              accept, deliver;
  logic              load_main_in, load_main_skid, load_skid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign vld_p0 = (state_p0 != EMPTY);

  // With a skid entry, in_ready depends only on registered state.
  if (SKID != 0) begin : g_skid_ready
    assign in_ready = (state_p0 != SKIDDED);
  end else begin : g_comb_ready
    assign in_ready = !vld_p0 | out_ready;
  end

  assign accept  = in_valid & in_ready & !flush;
  assign deliver = vld_p0 & out_ready;

  always_comb begin
    state_nxt      = state_p0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_p0)
      EMPTY: begin
        if (accept) begin
          state_nxt    = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (deliver) begin
          if (accept) load_main_in = 1'b1;
          else        state_nxt    = EMPTY;
        end else if (accept) begin
          state_nxt = SKIDDED;
          load_skid = 1'b1;
        end
      end
      SKIDDED: begin
        if (deliver) begin
          state_nxt      = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p0 <= EMPTY;
    else        state_p0 <= state_nxt;
  end

  // Stage boundary: head and skid entries; head payload is held while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_p0 <= '0;
      main_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
    end else begin
      if (load_main_in) begin
        main_data_p0 <= in_data;
        main_ctrl_p0 <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_p0 <= skid_data_p0;
        main_ctrl_p0 <= skid_ctrl_p0;
      end
      if (load_skid) begin
        skid_data_p0 <= in_data;
        skid_ctrl_p0 <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    stall_cnt_p0 <= '0;
    else if (vld_p0 && !out_ready) stall_cnt_p0 <= sat_inc(stall_cnt_p0);
  end

  assign out_valid = vld_p0;
  assign out_data  = main_data_p0;
  assign out_ctrl  = vld_p0 ? main_ctrl_p0 : '0;
  assign stall_cnt = stall_cnt_p0;

endmodule
